// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduling slice.
//   lane_t        : 2-bit lane index, legal values 0..NUM_LANES-1
//   sched_state_t : scheduler FSM states
//   lane_inc      : next lane, wrapping modulo NUM_LANES
package obstacle_pkg;

  localparam int unsigned NUM_LANES  = 3;
  localparam int unsigned MAX_LEVEL  = 7;
  localparam int unsigned WAIT_SHIFT = 2;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  function automatic lane_t lane_inc(input lane_t l);
    return (l == lane_t'(NUM_LANES - 1)) ? '0 : l + lane_t'(1);
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Request/spawn bus between obstacle_generator, the scheduler and the
// obstacle datapath.
//   master : environment side (drives tick/start/difficulty/random/ready)
//   slave  : scheduler side (drives spawn_valid/spawn_lane/expired/level)
interface obstacle_scheduler_if;
  import obstacle_pkg::*;

  logic        tick_in;
  logic        start_timer;
  logic [3:0]  time_to_wait;
  logic [11:0] time_alive;
  logic [1:0]  random_lane;
  logic        spawn_ready;
  logic        spawn_valid;
  lane_t       spawn_lane;
  logic        expired_out;
  logic [2:0]  level_out;

  modport master (
    output tick_in, start_timer, time_to_wait, time_alive, random_lane,
           spawn_ready,
    input  spawn_valid, spawn_lane, expired_out, level_out
  );

  modport slave (
    input  tick_in, start_timer, time_to_wait, time_alive, random_lane,
           spawn_ready,
    output spawn_valid, spawn_lane, expired_out, level_out
  );
endinterface

// File: rtl/obstacle_scheduler_lane_picker.sv
// Combinational lane selection for the next spawn.
//   raw_lane_i  : raw LFSR lane (3 is out of range and gets remapped)
//   last_lane_i : most recently issued lane
//   prev_lane_i : lane issued before that
//   lane_o      : chosen lane, always 0..2
module lane_picker
  import obstacle_pkg::*;
(
  input  logic [1:0] raw_lane_i,
  input  lane_t      last_lane_i,
  input  lane_t      prev_lane_i,
  output lane_t      lane_o
);

  lane_t base;

  always_comb begin
    base = (raw_lane_i == 2'd3) ? lane_inc(last_lane_i) : lane_t'(raw_lane_i);
    // Avoid a third consecutive spawn in the same lane.
    if (base == last_lane_i && base == prev_lane_i)
      lane_o = lane_inc(base);
    else
      lane_o = base;
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Spawn timer / scheduler: waits a difficulty-adjusted number of game ticks
// after a start request, then issues one spawn (valid/ready) and pulses
// expired_out back to the generator.
//   clk_in   : system clock
//   rst_in   : active-low reset, asynchronous assert
//   sched_if : request/spawn bus (slave side)
module obstacle_scheduler
  import obstacle_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  obstacle_scheduler_if.slave  sched_if
);

  sched_state_t state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   level_q, level_d;
  lane_t        lane_q, lane_d;
  lane_t        last_q, last_d;
  lane_t        prev_q, prev_d;

  logic [11:0]  alive_shr;
  logic [2:0]   level_new;
  logic [5:0]   wait_base;
  logic [5:0]   load_val;
  lane_t        picked;

  lane_picker u_picker (
    .raw_lane_i  (sched_if.random_lane),
    .last_lane_i (last_q),
    .prev_lane_i (prev_q),
    .lane_o      (picked)
  );

  // Difficulty level and saturating counter load for a start request.
  always_comb begin
    alive_shr = sched_if.time_alive >> 8;
    level_new = (alive_shr > 12'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : alive_shr[2:0];
    wait_base = {sched_if.time_to_wait, 2'b00};
    load_val  = (wait_base > {3'b000, level_new}) ? wait_base - {3'b000, level_new}
                                                  : 6'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    lane_d  = lane_q;
    last_d  = last_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: begin
        if (sched_if.start_timer) begin
          level_d = level_new;
          cnt_d   = load_val;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sched_if.start_timer) begin
          level_d = level_new;
          cnt_d   = load_val;
        end else if (sched_if.tick_in) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = ISSUE;
            lane_d  = picked;
          end
        end
      end
      ISSUE: begin
        if (sched_if.spawn_ready) begin
          prev_d  = last_q;
          last_d  = lane_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= '0;
      lane_q  <= '0;
      last_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
    end
  end

  // Outputs come straight from state so reset clears them immediately.
  assign sched_if.spawn_valid = (state_q == ISSUE);
  assign sched_if.expired_out = (state_q == DONE);
  assign sched_if.spawn_lane  = lane_q;
  assign sched_if.level_out   = level_q;

endmodule
